// File: rtl/pe_packet_injector.sv
// PE-side packet injector: queues destination-addressed requests, builds XY mesh packets
// and offers them to the router's local port. Optional macro PE_TX_ALIGN_EN aligns offers to TX_PHASE.
module pe_packet_injector #(
  parameter logic [7:0]  MY_X       = 8'd0,
  parameter logic [7:0]  MY_Y       = 8'd0,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic        TX_PHASE   = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_dst_x,
  input  logic [7:0]  req_dst_y,
  input  logic [31:0] req_payload,
  input  logic        polarity,
  input  logic        pe_ri,
  output logic        pe_si,
  output logic [63:0] pe_di,
  output logic        req_err,
  output logic        busy,
  output logic [15:0] sent_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_OFFER} state_e;

  state_e        state_q, state_d;
  logic [62:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          req_err_q;
  logic [15:0]   sent_count_q;

  logic          dir_x, dir_y, out_of_range, to_self;
  logic [8:0]    hx, hy;
  logic [62:0]   enq_pkt, head;
  logic          push_hs, drop, push, xfer;
  logic          phase_ok, vc;

  // Header fields are derived at enqueue time; only the VC bit is decided at offer time.
  assign dir_x = req_dst_x < MY_X;
  assign dir_y = req_dst_y < MY_Y;
  assign hx = dir_x ? ({1'b0, MY_X} - {1'b0, req_dst_x}) : ({1'b0, req_dst_x} - {1'b0, MY_X});
  assign hy = dir_y ? ({1'b0, MY_Y} - {1'b0, req_dst_y}) : ({1'b0, req_dst_y} - {1'b0, MY_Y});
  assign out_of_range = (hx > 9'd15) | (hy > 9'd15);
  assign to_self = (req_dst_x == MY_X) & (req_dst_y == MY_Y);
  assign enq_pkt = {dir_x, dir_y, 5'b0, hx[3:0], hy[3:0], MY_X, MY_Y, req_payload};

  assign req_ready = (count_q != FULL_CNT);
  assign busy      = (count_q != '0);
  assign push_hs   = req_valid & req_ready;
  assign drop      = push_hs & (out_of_range | to_self);
  assign push      = push_hs & ~drop;

`ifdef PE_TX_ALIGN_EN
  assign phase_ok = (polarity == TX_PHASE);
  assign vc       = TX_PHASE;
`else
  logic unused_tx_phase;
  assign unused_tx_phase = TX_PHASE;
  assign phase_ok = 1'b1;
  assign vc       = polarity;
`endif

  assign head  = mem_q[rd_ptr_q];
  assign pe_si = (state_q == S_OFFER) & phase_ok;
  assign pe_di = pe_si ? {vc, head} : 64'h0;
  assign xfer  = pe_si & pe_ri;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    state_d  = state_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (xfer) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, xfer})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    case (state_q)
      S_IDLE:  if (count_d != '0) state_d = S_OFFER;
      S_OFFER: if (xfer && (count_d == '0)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      req_err_q    <= 1'b0;
      sent_count_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      req_err_q <= drop;
      if (xfer) sent_count_q <= sent_count_q + 16'd1;
    end
  end

  // NOTE: the storage array is not reset; entries are only read once count_q marks them valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= enq_pkt;
  end

  assign req_err    = req_err_q;
  assign sent_count = sent_count_q;

endmodule

// File: tb/tb_pe_packet_injector.sv
// Self-checking bench for pe_packet_injector (MY=(1,1), depth 4): directed scenarios plus
// randomized traffic compared every cycle against a queue-based packet model.
module tb_pe_packet_injector;

  localparam logic TX_PHASE = 1'b0;
  localparam int   DEPTH    = 4;

  logic        clk, reset, req_valid, req_ready, polarity, pe_ri, pe_si, req_err, busy;
  logic [7:0]  req_dst_x, req_dst_y;
  logic [31:0] req_payload;
  logic [63:0] pe_di;
  logic [15:0] sent_count;

  int n_checks = 0;
  int n_errors = 0;
  bit started  = 0;

  pe_packet_injector #(.MY_X(8'd1), .MY_Y(8'd1), .FIFO_DEPTH(DEPTH), .TX_PHASE(TX_PHASE)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_dst_x(req_dst_x), .req_dst_y(req_dst_y), .req_payload(req_payload),
    .polarity(polarity), .pe_ri(pe_ri), .pe_si(pe_si), .pe_di(pe_di),
    .req_err(req_err), .busy(busy), .sent_count(sent_count)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    polarity = 0;
    forever begin
      @(posedge clk);
      #1 polarity = ~polarity;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what a request turns into, straight from the addressing rules.
  typedef struct {
    bit          drop;
    logic [62:0] pkt;
  } req_t;

  function automatic req_t build(int mx, int my, int dx, int dy, logic [31:0] pl);
    req_t r;
    int hx = dx - mx;
    int hy = dy - my;
    bit west  = hx < 0;
    bit north = hy < 0;
    if (west)  hx = -hx;
    if (north) hy = -hy;
    r.drop = (hx > 15) || (hy > 15) || (dx == mx && dy == my);
    r.pkt  = {west, north, 5'b0, 4'(hx), 4'(hy), 8'(mx), 8'(my), pl};
    return r;
  endfunction

  logic [62:0] m_q[$];
  bit          m_err = 0;
  logic [15:0] m_cnt = 0;

  function automatic bit m_si();
`ifdef PE_TX_ALIGN_EN
    return (m_q.size() != 0) && (polarity == TX_PHASE);
`else
    return m_q.size() != 0;
`endif
  endfunction

  function automatic bit m_vc();
`ifdef PE_TX_ALIGN_EN
    return TX_PHASE;
`else
    return polarity;
`endif
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q.delete();
      m_err <= 1'b0;
      m_cnt <= 16'd0;
    end else begin
      req_t r;
      bit xfer, hs;
      xfer = m_si() && pe_ri;
      hs   = req_valid && (m_q.size() < DEPTH);
      r    = build(1, 1, int'(req_dst_x), int'(req_dst_y), req_payload);
      if (xfer) begin
        void'(m_q.pop_front());
        m_cnt <= m_cnt + 16'd1;
      end
      if (hs && !r.drop) m_q.push_back(r.pkt);
      m_err <= hs && r.drop;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      bit si;
      si = m_si();
      check("pe_si", {63'b0, pe_si}, {63'b0, si});
      check("pe_di", pe_di, si ? {m_vc(), m_q[0]} : 64'h0);
      check("req_ready", {63'b0, req_ready}, {63'b0, m_q.size() < DEPTH});
      check("busy", {63'b0, busy}, {63'b0, m_q.size() != 0});
      check("req_err", {63'b0, req_err}, {63'b0, m_err});
      check("sent_count", {48'b0, sent_count}, {48'b0, m_cnt});
    end
  end

  // Presents one request and holds it until the DUT handshakes (bounded).
  task automatic push(input int dx, input int dy, input logic [31:0] pl);
    bit rdy = 0;
    req_valid   = 1;
    req_dst_x   = 8'(dx);
    req_dst_y   = 8'(dy);
    req_payload = pl;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      rdy = req_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
    end
    req_valid = 0;
    if (!rdy) check("push_timeout", {63'b0, rdy}, 64'd1);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    req_t r;
    logic [63:0] d0, dp;
    reset = 1; req_valid = 0; pe_ri = 0;
    req_dst_x = 0; req_dst_y = 0; req_payload = 0;
    #2 reset = 0;
    started = 1;
    repeat (2) @(posedge clk);
    #3 reset = 1;
    next_cycle();

    // Model pins against hand-computed packets and drop boundaries.
    r = build(4, 4, 0, 1, 32'h12345678);
    check("model_west_north", {1'b0, r.pkt}, 64'h6043_0404_1234_5678 & 64'h7FFF_FFFF_FFFF_FFFF);
    r = build(1, 1, 3, 2, 32'hFEEDBEEF);
    check("model_single", {1'b0, r.pkt}, 64'h0021_0101_FEED_BEEF);
    r = build(1, 1, 16, 16, 0);
    check("model_hx15_kept", {63'b0, r.drop}, 64'd0);
    r = build(1, 1, 17, 1, 0);
    check("model_hx16_drop", {63'b0, r.drop}, 64'd1);

    @(negedge clk);
    check("rst_pe_si", {63'b0, pe_si}, 64'd0);
    check("rst_pe_di", pe_di, 64'd0);
    check("rst_req_ready", {63'b0, req_ready}, 64'd1);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_sent_count", {48'b0, sent_count}, 64'd0);
    next_cycle();

    // Single packet
    pe_ri = 1;
    push(3, 2, 32'hFEEDBEEF);
    @(negedge clk);
    check("single_si", {63'b0, pe_si}, 64'd1);
    check("single_di", {1'b0, pe_di[62:0]}, 64'h0021_0101_FEED_BEEF);
    check("single_vc", {63'b0, pe_di[63]}, {63'b0, polarity});
    next_cycle();
    @(negedge clk);
    check("single_count", {48'b0, sent_count}, 64'd1);
    check("single_idle", {63'b0, busy}, 64'd0);
    next_cycle();

    // Drops: out of range and self-addressed
    push(20, 1, 32'h1);
    @(negedge clk);
    check("drop_far_err", {63'b0, req_err}, 64'd1);
    check("drop_far_busy", {63'b0, busy}, 64'd0);
    check("drop_far_si", {63'b0, pe_si}, 64'd0);
    next_cycle();
    @(negedge clk);
    check("drop_far_pulse", {63'b0, req_err}, 64'd0);
    next_cycle();
    push(1, 1, 32'h2);
    @(negedge clk);
    check("drop_self_err", {63'b0, req_err}, 64'd1);
    check("drop_self_busy", {63'b0, busy}, 64'd0);
    next_cycle();

    // Back-pressure with two queued packets
    pe_ri = 0;
    push(2, 3, 32'hA1A1A1A1);
    push(0, 0, 32'hA2A2A2A2);
    @(negedge clk);
    d0 = pe_di;
    dp = pe_di;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_si", {63'b0, pe_si}, 64'd1);
      check("bp_stable", {1'b0, pe_di[62:0]}, {1'b0, d0[62:0]});
      check("bp_vc_toggle", {63'b0, pe_di[63]}, {63'b0, ~dp[63]});
      dp = pe_di;
    end
    next_cycle();
    pe_ri = 1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("bp_drained_count", {48'b0, sent_count}, 64'd3);
    check("bp_drained_busy", {63'b0, busy}, 64'd0);
    next_cycle();

    // Fill to full, fifth request waits for the first pop
    pe_ri = 0;
    for (int i = 0; i < 4; i++) push(i + 2, 1, 32'hC0DE_0000 + i);
    @(negedge clk);
    check("fill_full", {63'b0, req_ready}, 64'd0);
    next_cycle();
    fork
      push(6, 1, 32'hC0DE_0004);
      begin
        repeat (3) @(posedge clk);
        #1 pe_ri = 1;
      end
    join
    repeat (10) next_cycle();
    @(negedge clk);
    check("fill_count", {48'b0, sent_count}, 64'd8);
    check("fill_empty", {63'b0, busy}, 64'd0);
    next_cycle();

    // Asynchronous reset in the middle of an offer
    pe_ri = 0;
    push(2, 2, 32'hD1);
    push(3, 3, 32'hD2);
    push(4, 4, 32'hD3);
    @(negedge clk);
    check("rst_mid_pre_si", {63'b0, pe_si}, 64'd1);
    @(posedge clk);
    #3 reset = 0;
    #1;
    check("rst_mid_si", {63'b0, pe_si}, 64'd0);
    check("rst_mid_busy", {63'b0, busy}, 64'd0);
    check("rst_mid_count", {48'b0, sent_count}, 64'd0);
    @(posedge clk);
    #3 reset = 1;
    pe_ri = 1;
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_no_stale", {63'b0, pe_si}, 64'd0);
    end
    next_cycle();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      req_valid   = 1'($urandom_range(0, 1));
      req_dst_x   = 8'($urandom_range(0, 20));
      req_dst_y   = 8'($urandom_range(0, 20));
      req_payload = $urandom;
      pe_ri       = ($urandom_range(0, 3) != 0);
      next_cycle();
    end
    req_valid = 0;
    pe_ri = 1;
    repeat (20) next_cycle();
    @(negedge clk);
    check("final_empty", {63'b0, busy}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pe_packet_injector.md
# pe_packet_injector

PE-side transmitter that feeds a cardinal router's local (PE) input port. It accepts destination-addressed requests from the processing element and queues them in a small FIFO. For each request it builds a 64-bit mesh packet with XY hop fields, then offers it to the router on `pe_si`/`pe_di` and waits for the router's `pe_ri`. It also keeps the VC bit consistent with the router's even/odd `polarity`.

## Interface
- `MY_X`, default 8'd0: this node's X coordinate; also the SRCX field.
- `MY_Y`, default 8'd0: this node's Y coordinate; also the SRCY field.
- `FIFO_DEPTH`, default 4: request queue entries; must be a power of 2, at least 2.
- `TX_PHASE`, default 1'b0: injection polarity, used only when `PE_TX_ALIGN_EN` is defined.
- `clk` in 1: clock; all state is clocked on the rising edge.
- `reset` in 1: asynchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: FIFO not full. Reset value 1.
- `req_dst_x` in 8: destination X.
- `req_dst_y` in 8: destination Y.
- `req_payload` in 32: packet payload.
- `polarity` in 1: router phase; toggles every cycle.
- `pe_ri` in 1: router ready for the PE input.
- `pe_si` out 1: packet offered. Reset value 0.
- `pe_di` out 64: packet. Reset value 0.
- `req_err` out 1: one-cycle pulse when a request is dropped. Reset value 0.
- `busy` out 1: FIFO non-empty. Reset value 0.
- `sent_count` out 16: accepted packets. Reset value 0; wraps modulo 2^16.

## Operation
- Packet layout: [63] VC, [62] DX (0=E, 1=W), [61] DY (0=S, 1=N), [60:56] RSV=0, [55:52] HX, [51:48] HY, [47:40] SRCX=MY_X, [39:32] SRCY=MY_Y, [31:0] payload.
- Enqueue happens when `req_valid & req_ready` at a clock edge. Header fields are computed at enqueue and stored; the VC bit is not stored.
- X direction:
  - DX=1 if dst_x < MY_X, else 0.
  - HX = |dst_x − MY_X|, computed at 9-bit width.
- Y direction:
  - DY=1 (north) if dst_y < MY_Y, else 0.
  - HY = |dst_y − MY_Y|, computed at 9-bit width.
- Drop rules. A handshaken request is dropped, not stored, and `req_err` pulses in the next cycle if:
  - HX > 15 or HY > 15, or
  - the destination is this node (dst equals MY_X, MY_Y).
- FSM has two states:
  - IDLE (FIFO empty) → OFFER when the FIFO becomes non-empty.
  - OFFER → IDLE when the head is accepted and the FIFO becomes empty. Otherwise stay in OFFER and present the next head back-to-back.
- Transfer occurs at a rising edge with `pe_si & pe_ri`. On transfer: pop the head and increment `sent_count`.
- `pe_si` = (state==OFFER) & phase_ok, where phase_ok is defined under Configuration.
- `pe_di` = {VC, stored head[62:0]} while `pe_si`=1, else 64'h0.
- Back-pressure: while `pe_ri`=0 the head is held; no data bits except VC may change.
- Simultaneous push and pop:
  - Both take effect and the occupancy is unchanged.
  - `req_ready` depends only on full; there is no bypass.
  - A push into an empty FIFO is offered no earlier than the next cycle.
- Reset asserted mid-operation: FIFO emptied, FSM to IDLE, `pe_si` drops immediately (asynchronous), and any in-flight offer is discarded.

## Timing
- Latency: request accepted at edge N → `pe_si`=1 in cycle N+1 at the earliest. Alignment may add one cycle.
- Throughput: one packet per cycle without alignment; one per 2 cycles with alignment.
- `pe_si` and `pe_di` are combinational from registered state, `polarity` and the FIFO head only. There is no combinational path from `pe_ri` to `pe_si`.
- `req_err` is registered: high for exactly one cycle, the cycle after the dropping edge.
- `sent_count` updates at the accepting edge.

## Configuration
- `PE_TX_ALIGN_EN` defined:
  - phase_ok = (`polarity` == TX_PHASE) and VC = TX_PHASE.
  - An unaccepted offer retries 2 cycles later.
- `PE_TX_ALIGN_EN` undefined:
  - phase_ok = 1 and VC = `polarity` in the offer cycle.
  - An unaccepted offer re-offers the next cycle with the VC bit flipped.

## Test plan
- Single packet: MY=(1,1), dst=(3,2), payload 32'hFEEDBEEF, `pe_ri`=1 → one transfer with `pe_di`[62:0] = {0,0,5'h0,4'd2,4'd1,8'h01,8'h01,32'hFEEDBEEF}. [63] must equal `polarity` (TX_PHASE when aligned). `sent_count` goes 0→1.
- Westward/northward packet: MY=(4,4), dst=(0,1) → DX=1, DY=1, HX=4, HY=3.
- Drop: dst=(20,1) with MY=(1,1) → `req_err` 1-cycle pulse, no `pe_si`, `busy` stays 0. Same response for dst=(1,1).
- Back-pressure, not aligned: hold `pe_ri`=0 for 5 cycles with 2 queued packets → `pe_si` stays 1, `pe_di`[62:0] is stable, and the VC bit toggles each cycle. After `pe_ri`=1, both packets transfer in 2 consecutive cycles, in order.
- Fill: push 5 requests with `pe_ri`=0 and FIFO_DEPTH=4 → `req_ready`=0 after the 4th. The 5th enqueues on the cycle after the first pop. All 5 arrive in order.
- Reset pulse while `pe_si`=1 with 3 queued → `pe_si`=0 within the same cycle, `busy`=0, `sent_count`=0. No stale packet is offered after reset is released.
